axi_stream_upsizer: RTL and testbench

- Native-RTL, single-clock AXI-Stream width upconverter: packs RATIO narrow input beats into one wide output beat, with byte-enable (tkeep) support.
- Built-in output FIFO replaces the vendor FIFO plus width-converter pair in 32-to-64-bit ingress paths.
- Adds partial-word flush on tlast and an optional idle-timeout flush.
- Sits between a packet source (e.g. a link deframer) and wide-datapath consumers; any clock-domain crossing stays outside this block.

---
 rtl/axi_stream_upsizer_pkg.sv | 25 ++
 rtl/axi_stream_sync_fifo.sv | 58 +++++
 rtl/axi_stream_upsizer.sv | 141 ++++++++++++++
 tb/tb_axi_stream_upsizer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_upsizer_pkg.sv
// rtl/axi_stream_upsizer_pkg.sv - shared width helpers and packing state type for the upsizer
package axi_stream_upsizer_pkg;

  typedef enum logic {
    PACK_EMPTY,
    PACK_PARTIAL
  } packState_e;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int keepWidth(input int width);
    return width / 8;
  endfunction

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_stream_sync_fifo.sv
// rtl/axi_stream_sync_fifo.sv - single-clock FIFO with full/empty/level, async active-low reset
module axi_stream_sync_fifo
  import axi_stream_upsizer_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   wrEn,
  input  logic [WIDTH-1:0]       wrData,
  input  logic                   rdEn,
  output logic [WIDTH-1:0]       rdData,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [LEVEL_W-1:0] levelReg;
  logic               doWrite;
  logic               doRead;

  assign full    = (levelReg == LEVEL_W'(DEPTH));
  assign empty   = (levelReg == '0);
  assign level   = levelReg;
  assign doWrite = wrEn & ~full;
  assign doRead  = rdEn & ~empty;

  // Read data is forced to zero when empty so reset never exposes stale storage.
  assign rdData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      levelReg <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (doRead)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doWrite, doRead})
        2'b10:   levelReg <= levelReg + LEVEL_W'(1);
        2'b01:   levelReg <= levelReg - LEVEL_W'(1);
        default: levelReg <= levelReg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/axi_stream_upsizer.sv
// rtl/axi_stream_upsizer.sv - packs RATIO narrow stream beats into one wide word, with tlast and idle-timeout flush
module axi_stream_upsizer
  import axi_stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH      = 32,
  parameter int RATIO         = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [IN_WIDTH-1:0]           sAxiStreamTdata,
  input  logic [IN_WIDTH/8-1:0]         sAxiStreamTkeep,
  input  logic                          sAxiStreamTlast,
  input  logic                          sAxiStreamTvalid,
  output logic                          sAxiStreamTready,
  output logic [IN_WIDTH*RATIO-1:0]     mAxiStreamTdata,
  output logic [IN_WIDTH*RATIO/8-1:0]   mAxiStreamTkeep,
  output logic                          mAxiStreamTlast,
  output logic                          mAxiStreamTvalid,
  input  logic                          mAxiStreamTready,
  output logic [clog2(FIFO_DEPTH):0]    fifoLevel,
  output logic [15:0]                   flushCount
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int IN_KEEP   = keepWidth(IN_WIDTH);
  localparam int OUT_KEEP  = keepWidth(OUT_WIDTH);
  localparam int LANE_W    = clog2(RATIO);
  localparam int FIFO_W    = OUT_WIDTH + OUT_KEEP + 1;
  localparam int CNT_W     = (FLUSH_TIMEOUT > 1) ? clog2(FLUSH_TIMEOUT) : 1;
  localparam int TO_MAX    = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;

  if ((IN_WIDTH % 8 != 0) || !isPow2(RATIO) || (RATIO < 2) || (RATIO > 8) ||
      (FIFO_DEPTH < 2) || !isPow2(FIFO_DEPTH)) begin : gParamCheck
    $error("axi_stream_upsizer: illegal IN_WIDTH/RATIO/FIFO_DEPTH combination");
  end

  packState_e          state;
  packState_e          stateNext;
  logic [LANE_W-1:0]   laneIdx;
  logic [OUT_WIDTH-1:0] accData;
  logic [OUT_WIDTH-1:0] wordData;
  logic [OUT_KEEP-1:0] accKeep;
  logic [OUT_KEEP-1:0] wordKeep;
  logic [CNT_W-1:0]    idleCnt;
  logic                readyEn;
  logic                accept;
  logic                complete;
  logic                flushFire;
  logic                fifoWrEn;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [FIFO_W-1:0]   fifoDout;

  // Ready comes only from registered state, so it is low in reset and rises one edge later.
  assign sAxiStreamTready = readyEn & ~fifoFull;
  assign accept           = sAxiStreamTvalid & sAxiStreamTready;
  assign complete         = accept & ((laneIdx == LANE_W'(RATIO - 1)) | sAxiStreamTlast);

  // Fires during the FLUSH_TIMEOUT-th consecutive idle cycle of a partial word.
  if (FLUSH_TIMEOUT > 0) begin : gFlush
    assign flushFire = (state == PACK_PARTIAL) & ~accept & ~fifoFull &
                       (idleCnt == CNT_W'(TO_MAX));
  end else begin : gNoFlush
    assign flushFire = 1'b0;
  end

  assign fifoWrEn = complete | flushFire;

  always_comb begin
    wordData = accData;
    wordKeep = accKeep;
    for (int j = 0; j < RATIO; j++) begin
      if (accept && (laneIdx == LANE_W'(j))) begin
        wordData[j*IN_WIDTH +: IN_WIDTH] = sAxiStreamTdata;
        wordKeep[j*IN_KEEP +: IN_KEEP]   = sAxiStreamTkeep;
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (fifoWrEn) begin
      stateNext = PACK_EMPTY;
    end else if (accept) begin
      stateNext = PACK_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= PACK_EMPTY;
      readyEn    <= 1'b0;
      laneIdx    <= '0;
      accData    <= '0;
      accKeep    <= '0;
      idleCnt    <= '0;
      flushCount <= '0;
    end else begin
      state   <= stateNext;
      readyEn <= 1'b1;
      if (fifoWrEn) begin
        laneIdx <= '0;
        accData <= '0;
        accKeep <= '0;
      end else if (accept) begin
        laneIdx <= laneIdx + LANE_W'(1);
        accData <= wordData;
        accKeep <= wordKeep;
      end
      if ((FLUSH_TIMEOUT == 0) || (state == PACK_EMPTY) || accept || flushFire) begin
        idleCnt <= '0;
      end else if (idleCnt != CNT_W'(TO_MAX)) begin
        idleCnt <= idleCnt + CNT_W'(1);
      end
      if (flushFire && (flushCount != 16'hFFFF)) begin
        flushCount <= flushCount + 16'd1;
      end
    end
  end

  axi_stream_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .resetN (resetN),
    .wrEn   (fifoWrEn),
    .wrData ({complete & sAxiStreamTlast, wordKeep, wordData}),
    .rdEn   (mAxiStreamTready),
    .rdData (fifoDout),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (fifoLevel)
  );

  assign mAxiStreamTvalid = ~fifoEmpty;
  assign {mAxiStreamTlast, mAxiStreamTkeep, mAxiStreamTdata} = fifoDout;

endmodule

// File: tb/tb_axi_stream_upsizer.sv
// tb/tb_axi_stream_upsizer.sv - directed bench for default, timeout-flush and 16-bit x4 upsizer builds
module tb_axi_stream_upsizer;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] aData = '0;
  logic [3:0]  aKeep = '0;
  logic        aLast = 1'b0, aValid = 1'b0, aReady;
  logic [63:0] amData;
  logic [7:0]  amKeep;
  logic        amLast, amValid, amReady = 1'b0;
  logic [4:0]  aLevel;
  logic [15:0] aFlush;

  logic [31:0] tData = '0;
  logic [3:0]  tKeep = '0;
  logic        tLast = 1'b0, tValid = 1'b0, tReady;
  logic [63:0] tmData;
  logic [7:0]  tmKeep;
  logic        tmLast, tmValid, tmReady = 1'b0;
  logic [4:0]  tLevel;
  logic [15:0] tFlush;

  logic [15:0] rData = '0;
  logic [1:0]  rKeep = '0;
  logic        rLast = 1'b0, rValid = 1'b0, rReady;
  logic [63:0] rmData;
  logic [7:0]  rmKeep;
  logic        rmLast, rmValid, rmReady = 1'b0;
  logic [2:0]  rLevel;
  logic [15:0] rFlush;

  axi_stream_upsizer uA (
    .clk(clk), .resetN(resetN),
    .sAxiStreamTdata(aData), .sAxiStreamTkeep(aKeep), .sAxiStreamTlast(aLast),
    .sAxiStreamTvalid(aValid), .sAxiStreamTready(aReady),
    .mAxiStreamTdata(amData), .mAxiStreamTkeep(amKeep), .mAxiStreamTlast(amLast),
    .mAxiStreamTvalid(amValid), .mAxiStreamTready(amReady),
    .fifoLevel(aLevel), .flushCount(aFlush)
  );

  axi_stream_upsizer #(.FLUSH_TIMEOUT(8)) uT (
    .clk(clk), .resetN(resetN),
    .sAxiStreamTdata(tData), .sAxiStreamTkeep(tKeep), .sAxiStreamTlast(tLast),
    .sAxiStreamTvalid(tValid), .sAxiStreamTready(tReady),
    .mAxiStreamTdata(tmData), .mAxiStreamTkeep(tmKeep), .mAxiStreamTlast(tmLast),
    .mAxiStreamTvalid(tmValid), .mAxiStreamTready(tmReady),
    .fifoLevel(tLevel), .flushCount(tFlush)
  );

  axi_stream_upsizer #(.IN_WIDTH(16), .RATIO(4), .FIFO_DEPTH(4)) uR (
    .clk(clk), .resetN(resetN),
    .sAxiStreamTdata(rData), .sAxiStreamTkeep(rKeep), .sAxiStreamTlast(rLast),
    .sAxiStreamTvalid(rValid), .sAxiStreamTready(rReady),
    .mAxiStreamTdata(rmData), .mAxiStreamTkeep(rmKeep), .mAxiStreamTlast(rmLast),
    .mAxiStreamTvalid(rmValid), .mAxiStreamTready(rmReady),
    .fifoLevel(rLevel), .flushCount(rFlush)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beatA(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    aValid = 1'b1; aData = d; aKeep = k; aLast = l;
    while (!aReady && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!aReady) chk("beatA_ready_timeout", aReady, 1'b1);
    @(posedge clk); #1;
    aValid = 1'b0;
  endtask

  task automatic beatR(input logic [15:0] d, input logic [1:0] k, input logic l);
    rValid = 1'b1; rData = d; rKeep = k; rLast = l;
    @(posedge clk); #1;
    rValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int inIdx;
    int outIdx;
    logic acc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sReady", aReady, 1'b0);
    chk("rst_mValid", amValid, 1'b0);
    chk("rst_mData", amData, 64'h0);
    chk("rst_level", aLevel, 5'd0);
    chk("rst_flushCount", tFlush, 16'd0);
    resetN = 1'b1;
    #1;
    chk("ready_before_edge", aReady, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", aReady, 1'b1);

    // Two-beat packet
    beatA(32'h11111111, 4'hF, 1'b0);
    chk("t1_valid_after_beat1", amValid, 1'b0);
    beatA(32'h22222222, 4'hF, 1'b1);
    chk("t1_valid", amValid, 1'b1);
    chk("t1_data", amData, 64'h22222222_11111111);
    chk("t1_keep", amKeep, 8'hFF);
    chk("t1_last", amLast, 1'b1);
    amReady = 1'b1;
    @(posedge clk); #1;
    chk("t1_drained", aLevel, 5'd0);

    // Three-beat packet ending in a half word
    amReady = 1'b0;
    beatA(32'hA, 4'hF, 1'b0);
    beatA(32'hB, 4'hF, 1'b0);
    beatA(32'hC, 4'hF, 1'b1);
    chk("t2_level", aLevel, 5'd2);
    chk("t2_w0_data", amData, 64'h0000000B_0000000A);
    chk("t2_w0_keep", amKeep, 8'hFF);
    chk("t2_w0_last", amLast, 1'b0);
    amReady = 1'b1;
    @(posedge clk); #1;
    chk("t2_w1_data", amData, 64'h00000000_0000000C);
    chk("t2_w1_keep", amKeep, 8'h0F);
    chk("t2_w1_last", amLast, 1'b1);
    @(posedge clk); #1;
    chk("t2_empty", amValid, 1'b0);

    // Backpressure: fill to 16 words, hold beat 32, then drain all 20 words
    amReady = 1'b0;
    for (int i = 0; i < 32; i++) beatA(32'h10000000 + 32'(i), 4'hF, 1'b0);
    chk("t3_level_full", aLevel, 5'd16);
    chk("t3_ready_low", aReady, 1'b0);
    aValid = 1'b1; aData = 32'h10000000 + 32'd32; aKeep = 4'hF; aLast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_level_hold", aLevel, 5'd16);
    chk("t3_ready_hold", aReady, 1'b0);
    amReady = 1'b1;
    inIdx = 32;
    outIdx = 0;
    for (int c = 0; c < 200 && outIdx < 20; c++) begin
      if (amValid) begin
        chk($sformatf("t3_word%0d", outIdx), amData,
            {32'h10000000 + 32'(2*outIdx + 1), 32'h10000000 + 32'(2*outIdx)});
        outIdx++;
      end
      acc = aValid & aReady;
      @(posedge clk); #1;
      if (acc) inIdx++;
      aValid = (inIdx < 40);
      aData  = 32'h10000000 + 32'(inIdx);
    end
    chk("t3_words_out", outIdx, 20);
    chk("t3_beats_in", inIdx, 40);
    chk("t3_level_end", aLevel, 5'd0);

    // Idle-timeout flush on the FLUSH_TIMEOUT=8 build
    tValid = 1'b1; tData = 32'h5; tKeep = 4'hF; tLast = 1'b0;
    @(posedge clk); #1;
    tValid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("to_no_flush_at7", tmValid, 1'b0);
    @(posedge clk); #1;
    chk("to_valid", tmValid, 1'b1);
    chk("to_data", tmData, 64'h5);
    chk("to_keep", tmKeep, 8'h0F);
    chk("to_last", tmLast, 1'b0);
    chk("to_flushCount", tFlush, 16'd1);
    tmReady = 1'b1;
    @(posedge clk); #1;
    tmReady = 1'b0;
    tValid = 1'b1; tData = 32'h6; tKeep = 4'hF; tLast = 1'b0;
    @(posedge clk); #1;
    tValid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tValid = 1'b1; tData = 32'h7; tKeep = 4'h3; tLast = 1'b0;
    @(posedge clk); #1;
    tValid = 1'b0;
    chk("to_beat_wins_data", tmData, 64'h00000007_00000006);
    chk("to_beat_wins_keep", tmKeep, 8'h3F);
    repeat (12) @(posedge clk);
    #1;
    chk("to_beat_wins_count", tFlush, 16'd1);
    chk("to_beat_wins_level", tLevel, 5'd1);

    // 16-bit x4 build: sparse keep and a zero-keep lane
    beatR(16'h00AB, 2'b01, 1'b1);
    chk("r4_data", rmData, 64'h00000000_000000AB);
    chk("r4_keep", rmKeep, 8'h01);
    chk("r4_last", rmLast, 1'b1);
    rmReady = 1'b1;
    @(posedge clk); #1;
    rmReady = 1'b0;
    beatR(16'h1111, 2'b11, 1'b0);
    beatR(16'h2222, 2'b00, 1'b0);
    beatR(16'h3333, 2'b11, 1'b1);
    chk("r4_zero_lane_data", rmData, 64'h00003333_22221111);
    chk("r4_zero_lane_keep", rmKeep, 8'h33);

    // Reset mid-packet with three words queued
    amReady = 1'b0;
    for (int i = 0; i < 6; i++) beatA(32'hC0 + 32'(i), 4'hF, 1'b0);
    beatA(32'h99, 4'hF, 1'b0);
    chk("mr_level_before", aLevel, 5'd3);
    resetN = 1'b0;
    #1;
    chk("mr_sReady", aReady, 1'b0);
    chk("mr_mValid", amValid, 1'b0);
    chk("mr_mData", amData, 64'h0);
    chk("mr_mKeep", amKeep, 8'h0);
    chk("mr_level", aLevel, 5'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    beatA(32'h77, 4'hF, 1'b0);
    beatA(32'h88, 4'hF, 1'b1);
    chk("mr_next_data", amData, 64'h00000088_00000077);
    chk("mr_next_keep", amKeep, 8'hFF);
    chk("mr_next_last", amLast, 1'b1);
    chk("mr_next_level", aLevel, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
